// File: rtl/cond_pkg.sv
// Shared condition-code and flag-index definitions for the conditional
// execution back end.
package cond_pkg;

  localparam logic [3:0] COND_EQ   = 4'd0;
  localparam logic [3:0] COND_NE   = 4'd1;
  localparam logic [3:0] COND_CS   = 4'd2;
  localparam logic [3:0] COND_CC   = 4'd3;
  localparam logic [3:0] COND_MI   = 4'd4;
  localparam logic [3:0] COND_PL   = 4'd5;
  localparam logic [3:0] COND_VS   = 4'd6;
  localparam logic [3:0] COND_VC   = 4'd7;
  localparam logic [3:0] COND_HI   = 4'd8;
  localparam logic [3:0] COND_LS   = 4'd9;
  localparam logic [3:0] COND_GE   = 4'd10;
  localparam logic [3:0] COND_LT   = 4'd11;
  localparam logic [3:0] COND_GT   = 4'd12;
  localparam logic [3:0] COND_LE   = 4'd13;
  localparam logic [3:0] COND_AL   = 4'd14;
  localparam logic [3:0] COND_RSVD = 4'd15;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational evaluation of a 4-bit condition field against the
// registered {N,Z,C,V} flags.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v, ge;

  assign n  = flags[FLAG_N];
  assign z  = flags[FLAG_Z];
  assign c  = flags[FLAG_C];
  assign v  = flags[FLAG_V];
  assign ge = (n == v);

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = !z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = !c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = !n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = !v;
      COND_HI: cond_ex = c & !z;
      COND_LS: cond_ex = !c | z;
      COND_GE: cond_ex = ge;
      COND_LT: cond_ex = !ge;
      COND_GT: cond_ex = !z & ge;
      COND_LE: cond_ex = z | !ge;
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// NZCV flag register, condition-gated write enables and optional squash
// counter (enabled by defining COND_SQUASH_CNT_EN).
module cond_logic
  import cond_pkg::*;
#(
  parameter logic [3:0] FLAG_RST = 4'b0000,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             NoWrite,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             CondEx,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] squash_cnt
);

  logic [3:0] flags_q;
  logic       exec;

  // Condition uses only registered flags, never this cycle's ALUFlags.
  cond_check u_check (
    .cond    (Cond),
    .flags   (flags_q),
    .cond_ex (CondEx)
  );

  assign exec     = valid & CondEx;
  assign PCSrc    = exec & PCS;
  assign RegWrite = exec & RegW & !NoWrite;
  assign MemWrite = exec & MemW;
  assign Flags    = flags_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= FLAG_RST;
    end else if (exec) begin
      if (FlagW[1]) flags_q[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
      if (FlagW[0]) flags_q[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
    end
  end

`ifdef COND_SQUASH_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             squash;

  assign squash     = valid & !CondEx;
  assign squash_cnt = cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (squash && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
`else
  assign squash_cnt = '0;
`endif

endmodule

// File: tb/tb_cond_logic.sv
// Directed, table-driven bench for cond_logic.
module tb_cond_logic;

  localparam int CNT_W = 16;

  logic             clk;
  logic             reset;
  logic             valid;
  logic [3:0]       Cond;
  logic [3:0]       ALUFlags;
  logic [1:0]       FlagW;
  logic             NoWrite;
  logic             PCS;
  logic             RegW;
  logic             MemW;
  logic             PCSrc;
  logic             RegWrite;
  logic             MemWrite;
  logic             CondEx;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] squash_cnt;

  int total;
  int passed;
  int exp_cnt;

  typedef struct {
    logic [3:0]  cond;
    logic [15:0] mask;
  } vec_t;

  vec_t vecs[9];

  cond_logic #(
    .FLAG_RST (4'b0000),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .valid      (valid),
    .Cond       (Cond),
    .ALUFlags   (ALUFlags),
    .FlagW      (FlagW),
    .NoWrite    (NoWrite),
    .PCS        (PCS),
    .RegW       (RegW),
    .MemW       (MemW),
    .PCSrc      (PCSrc),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .CondEx     (CondEx),
    .Flags      (Flags),
    .squash_cnt (squash_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [3:0] c,
                       input logic [3:0] af, input logic [1:0] fw,
                       input logic nw, input logic pcs,
                       input logic rw, input logic mw);
    valid    = v;
    Cond     = c;
    ALUFlags = af;
    FlagW    = fw;
    NoWrite  = nw;
    PCS      = pcs;
    RegW     = rw;
    MemW     = mw;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] f);
    drive(1'b1, 4'd14, f, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 4'd14, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_cnt(input string name);
`ifdef COND_SQUASH_CNT_EN
    chk(name, 32'(squash_cnt), 32'(exp_cnt));
`else
    chk(name, 32'(squash_cnt), 32'd0);
`endif
  endtask

  initial begin
    // mask bit f = expected CondEx when Flags == f ({N,Z,C,V})
    vecs[0] = '{4'd0,  16'hF0F0};
    vecs[1] = '{4'd8,  16'h0C0C};
    vecs[2] = '{4'd9,  16'hF3F3};
    vecs[3] = '{4'd10, 16'hAA55};
    vecs[4] = '{4'd11, 16'h55AA};
    vecs[5] = '{4'd12, 16'h0A05};
    vecs[6] = '{4'd13, 16'hF5FA};
    vecs[7] = '{4'd14, 16'hFFFF};
    vecs[8] = '{4'd15, 16'h0000};

    total   = 0;
    passed  = 0;
    exp_cnt = 0;
    reset   = 1'b1;
    drive(1'b0, 4'd14, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    chk("rst_flags", 32'(Flags), 32'h0);
    chk_cnt("rst_cnt");
    reset = 1'b0;
    step();

    // async reset with no clock edge
    load(4'b1111);
    chk("load_1111", 32'(Flags), 32'hF);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_flags", 32'(Flags), 32'h0);
    chk_cnt("async_rst_cnt");
    // flag write presented while reset is held is lost
    drive(1'b1, 4'd14, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("rst_hold_flags", 32'(Flags), 32'h0);
    reset = 1'b0;
    drive(1'b0, 4'd14, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step();

    // flag write then forwarding to next instruction
    drive(1'b1, 4'd14, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("fwd_c1_condex", 32'(CondEx), 32'd1);
    step();
    chk("fwd_c1_flags", 32'(Flags), 32'h4);
    drive(1'b1, 4'd0, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("fwd_c2_condex", 32'(CondEx), 32'd1);
    chk("fwd_c2_regwrite", 32'(RegWrite), 32'd1);
    step();
    chk("fwd_c2_hold", 32'(Flags), 32'h4);

    // split flag halves
    load(4'b0000);
    drive(1'b1, 4'd14, 4'b1111, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("split_nz", 32'(Flags), 32'hC);
    drive(1'b1, 4'd14, 4'b0011, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("split_cv", 32'(Flags), 32'hF);
    drive(1'b1, 4'd14, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("flagw_00_hold", 32'(Flags), 32'hF);

    // CMP-class: no register write, flags update
    drive(1'b1, 4'd14, 4'b1000, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    chk("cmp_regwrite", 32'(RegWrite), 32'd0);
    step();
    chk("cmp_flags", 32'(Flags), 32'h8);

    // squashed instruction
    load(4'b0100);
    drive(1'b1, 4'd1, 4'b1011, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1);
    #1;
    chk("sq_condex", 32'(CondEx), 32'd0);
    chk("sq_pcsrc", 32'(PCSrc), 32'd0);
    chk("sq_memwrite", 32'(MemWrite), 32'd0);
    chk("sq_regwrite", 32'(RegWrite), 32'd0);
    step();
    exp_cnt++;
    chk("sq_flags", 32'(Flags), 32'h4);
    chk_cnt("sq_cnt");

    // passing instruction drives every enable
    drive(1'b1, 4'd0, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
    #1;
    chk("pass_pcsrc", 32'(PCSrc), 32'd1);
    chk("pass_memwrite", 32'(MemWrite), 32'd1);
    chk("pass_regwrite", 32'(RegWrite), 32'd1);
    step();
    chk_cnt("pass_cnt");

    // valid=0: nothing changes
    drive(1'b0, 4'd14, 4'b1111, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1);
    #1;
    chk("inv_pcsrc", 32'(PCSrc), 32'd0);
    chk("inv_regwrite", 32'(RegWrite), 32'd0);
    chk("inv_memwrite", 32'(MemWrite), 32'd0);
    step();
    chk("inv_flags", 32'(Flags), 32'h4);
    chk_cnt("inv_cnt");
    drive(1'b0, 4'd15, 4'b1111, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    chk_cnt("inv_fail_cnt");

    // condition sweep over all flag values
    for (int f = 0; f < 16; f++) begin
      load(4'(f));
      for (int i = 0; i < 9; i++) begin
        Cond = vecs[i].cond;
        #1;
        chk($sformatf("cond%0d_f%0h", vecs[i].cond, f),
            32'(CondEx), 32'(vecs[i].mask[f]));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cond_logic.md
Name: cond_logic

Overview:
- Conditional-execution back end for the ARM-subset datapath; it consumes the FlagW and NoWrite outputs of the ALU decoder.
- Holds the architectural NZCV flag register.
- Evaluates the 4-bit condition field of each instruction against the stored flags.
- Gates PC, register-file and memory write enables, and updates flags at the clock edge when the instruction executes.

Parameters:
- FLAG_RST, 4'b0000, reset value of {N,Z,C,V}.
- CNT_W, 16, width of the squash counter (optional feature).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high; clears all state.
- valid  in  1  instruction present this cycle; qualifies all updates.
- Cond  in  4  instruction condition field [31:28].
- ALUFlags  in  4  {N,Z,C,V} produced by the ALU this cycle.
- FlagW  in  2  from decoder; [1] = write N,Z; [0] = write C,V.
- NoWrite  in  1  from decoder; suppresses register write (CMP/TST class).
- PCS  in  1  instruction writes PC.
- RegW  in  1  instruction writes register file.
- MemW  in  1  instruction writes memory.
- PCSrc  out  1  gated PC write.
- RegWrite  out  1  gated register write.
- MemWrite  out  1  gated memory write.
- CondEx  out  1  condition passed for the current instruction.
- Flags  out  4  current registered {N,Z,C,V}.
- squash_cnt  out  CNT_W  count of squashed instructions.

Behaviour:
- Reset (async, active-high): Flags=FLAG_RST, squash_cnt=0. All combinational outputs follow from these values.
- CondEx is combinational from Cond and the registered Flags only. ALUFlags of the same instruction never affect its own condition.
- Condition encoding:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z
  - 10 GE N==V; 11 LT N!=V
  - 12 GT !Z&(N==V); 13 LE Z|(N!=V)
  - 14 AL 1; 15 reserved → CondEx=0.
- Gated write enables (all combinational, zero latency):
  - PCSrc = valid & CondEx & PCS
  - RegWrite = valid & CondEx & RegW & !NoWrite
  - MemWrite = valid & CondEx & MemW
- Flag update at rising clk, gated by valid & CondEx:
  - if FlagW[1]: N,Z ← ALUFlags[3:2]
  - if FlagW[0]: C,V ← ALUFlags[1:0]
  - Halves update independently; FlagW=2'b00 holds the flags.
- valid=0: all write enables 0, flags hold, counter holds.
- Back-to-back instructions: a flag write at edge k is visible to the CondEx of the instruction in cycle k+1.
- Reset asserted mid-instruction: the flag write is lost; outputs go to reset values immediately.

Optional Feature:
- Macro: COND_SQUASH_CNT_EN.
- Defined: squash_cnt increments by 1 at each rising clk where valid & !CondEx. It saturates at all-ones and is cleared by reset.
- Undefined: no counter register; squash_cnt is driven constant 0.

Decomposition:
- Shared package cond_pkg holds:
  - the condition-code localparams COND_EQ..COND_AL and COND_RSVD;
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One sub-module, cond_check: purely combinational (Cond, Flags) → CondEx.
- cond_logic holds the flag register, enable gating and counter.

Test Plan:
- Reset: assert reset mid-cycle with Flags=4'b1111 → Flags=4'b0000 and squash_cnt=0 immediately, with no clock edge.
- Flag write and forwarding:
  - Cycle 1: valid=1, Cond=14, FlagW=2'b11, ALUFlags=4'b0100 → Flags=4'b0100 after the edge.
  - Cycle 2: Cond=0 (EQ), RegW=1 → CondEx=1, RegWrite=1.
- Split flag write: from Flags=4'b0000, apply FlagW=2'b10, ALUFlags=4'b1111, Cond=14 → Flags=4'b1100 (C,V unchanged).
- CMP-class instruction: Cond=14, RegW=1, NoWrite=1, FlagW=2'b11 → RegWrite=0 while flags update.
- Squash: Flags=4'b0100, Cond=1 (NE), PCS=1, MemW=1, FlagW=2'b11 → PCSrc=0, MemWrite=0, flags unchanged, squash_cnt +1 (with macro).
- Condition sweep and reserved code:
  - Sweep Cond=8..13 over all 16 flag values and compare CondEx to the encoding table.
  - Cond=15 → CondEx=0 for every flag value.
  - valid=0 with Cond=14 → all enables 0, flags and counter hold.
